// File: rtl/btn_event_unit.sv
// btn_event_unit: synchronises and debounces N_CH pushbuttons, generates
// press/release/auto-repeat pulses and queues them as events in a small
// first-word-fall-through FIFO with a valid/ready handshake.
module btn_event_unit #(
  parameter int N_CH         = 3,
  parameter int CH_W         = 2,
  parameter int DEB_CYCLES   = 2000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int CNT_W        = 26,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            evt_valid,
  output logic [CH_W-1:0] evt_ch,
  output logic [1:0]      evt_type,
  input  logic            evt_ready,
  output logic            overflow,
  input  logic            overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_e;

  logic [N_CH-1:0]            sync1, sync2;
  logic [N_CH-1:0][CNT_W-1:0] deb_cnt;
  logic [N_CH-1:0][CNT_W-1:0] rpt_cnt;
  logic [N_CH-1:0]            rpt_armed;
  logic [N_CH-1:0]            deb_hit, rise_nxt, fall_nxt, rpt_nxt;
  logic [N_CH-1:0]            new_evt, lost, pushed;
  logic [N_CH-1:0][1:0]       new_type;
  logic [N_CH-1:0]            slot_valid;
  logic [N_CH-1:0][1:0]       slot_type;
  logic [CH_W+1:0]            mem [FIFO_DEPTH];
  logic [AW:0]                wr_ptr, rd_ptr;
  logic                       empty, full, pop, push, slot_any;
  logic [CH_W-1:0]            push_ch;
  logic [1:0]                 push_type;

  // Two-flop synchroniser on the raw asynchronous buttons.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Decide this edge's level changes, edge events and auto-repeat events.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    deb_hit  = '0;
    rise_nxt = '0;
    fall_nxt = '0;
    rpt_nxt  = '0;
    new_evt  = '0;
    new_type = '0;
    for (int i = 0; i < N_CH; i++) begin
      deb_hit[i]  = (sync2[i] != btn_level[i]) && (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1));
      rise_nxt[i] = deb_hit[i] && !btn_level[i];
      fall_nxt[i] = deb_hit[i] && btn_level[i];
      rpt_nxt[i]  = btn_level[i] && repeat_en[i] && !fall_nxt[i] &&
                    (rpt_cnt[i] == (rpt_armed[i] ? CNT_W'(REPEAT_RATE - 1)
                                                 : CNT_W'(REPEAT_DELAY - 1)));
      new_evt[i]  = rise_nxt[i] || fall_nxt[i] || rpt_nxt[i];
      new_type[i] = rise_nxt[i] ? EVT_PRESS : (fall_nxt[i] ? EVT_RELEASE : EVT_REPEAT);
    end
  end

  // Debounce counters, accepted level and registered edge/repeat pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb_cnt       <= '0;
      btn_level     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if ((sync2[i] == btn_level[i]) || deb_hit[i]) deb_cnt[i] <= '0;
        else                                          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
      end
      btn_level     <= btn_level ^ deb_hit;
      press_pulse   <= rise_nxt;
      release_pulse <= fall_nxt;
      repeat_pulse  <= rpt_nxt;
    end
  end

  // Repeat timers: run while held with repeat enabled, first interval is the delay.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_armed <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!btn_level[i] || !repeat_en[i] || fall_nxt[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b0;
        end else if (rpt_nxt[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b1;
        end else begin
          rpt_cnt[i]   <= rpt_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && evt_ready;

  // Fixed-priority arbiter: lowest-index pending slot wins the single push.
  always_comb begin
    push_ch   = '0;
    push_type = '0;
    slot_any  = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (slot_valid[i]) begin
        push_ch   = CH_W'(i);
        push_type = slot_type[i];
        slot_any  = 1'b1;
      end
    end
    push   = slot_any && (!full || pop);
    pushed = '0;
    lost   = '0;
    for (int i = 0; i < N_CH; i++) begin
      pushed[i] = push && (push_ch == CH_W'(i));
      lost[i]   = new_evt[i] && slot_valid[i] && !pushed[i];
    end
  end

  // Pending slots and the sticky overflow flag (a new loss wins over a clear).
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_valid <= '0;
      slot_type  <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (new_evt[i] && !lost[i]) begin
          slot_valid[i] <= 1'b1;
          slot_type[i]  <= new_type[i];
        end else if (pushed[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      overflow <= (|lost) || (overflow && !overflow_clr);
    end
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; resetting pointers empties it and the read side is gated below.
    if (push) mem[wr_ptr[AW-1:0]] <= {push_ch, push_type};
  end

  assign evt_valid = !empty;
  assign evt_ch    = evt_valid ? mem[rd_ptr[AW-1:0]][CH_W+1:2] : '0;
  assign evt_type  = evt_valid ? mem[rd_ptr[AW-1:0]][1:0]      : 2'b00;

endmodule

// File: doc/btn_event_unit.md
Name: btn_event_unit

Overview:
- Parametrised successor to the per-button debouncer instances in the RTC/VGA top level.
- Conditions N_CH raw pushbuttons in one block:
  - synchronisation and debounce;
  - press/release edge pulses;
  - optional per-channel auto-repeat;
  - a small event FIFO with a valid/ready handshake, so the RTC control FSM can consume edit commands without missing presses while it is busy with bus cycles.

Parameters:
- N_CH, 3, number of button channels.
- CH_W, 2, width of the channel index; must satisfy 2**CH_W >= N_CH.
- DEB_CYCLES, 2000000, consecutive stable cycles required to accept a level change (20 ms at 100 MHz).
- REPEAT_DELAY, 50000000, cycles from accepted press to the first repeat.
- REPEAT_RATE, 10000000, cycles between subsequent repeats.
- CNT_W, 26, width of debounce and repeat counters; must hold the largest of the three counts above.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-low.
- btn_in  in  N_CH  raw asynchronous button inputs.
- repeat_en  in  N_CH  per-channel auto-repeat enable.
- btn_level  out  N_CH  debounced level.
- press_pulse  out  N_CH  one-cycle pulse on accepted rise.
- release_pulse  out  N_CH  one-cycle pulse on accepted fall.
- repeat_pulse  out  N_CH  one-cycle auto-repeat pulse.
- evt_valid  out  1  FIFO not empty.
- evt_ch  out  CH_W  channel of the head event.
- evt_type  out  2  head event type: 01 press, 10 release, 11 repeat.
- evt_ready  in  1  consumer accepts the head event.
- overflow  out  1  sticky flag; an event was lost.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - While reset is 0 at a clk edge, all outputs go to 0: btn_level, pulses, evt_valid, evt_ch, evt_type, overflow.
  - Reset also clears synchronisers, counters, pending slots and FIFO pointers.
- Synchroniser: 2-flop synchroniser per channel.
- Debounce, per channel:
  - The counter increments every cycle that the synchronised input differs from btn_level, and clears whenever it matches.
  - When the counter reaches DEB_CYCLES-1 and the input still differs, btn_level toggles and the counter clears.
- Latency: a clean edge on btn_in is visible on btn_level exactly 2+DEB_CYCLES cycles later.
  - A glitch shorter than DEB_CYCLES synchronised cycles produces no change.
- Edge pulses:
  - press_pulse[i] / release_pulse[i] are high for exactly the first cycle in which btn_level[i] shows its new value.
- Auto-repeat, only when repeat_en[i]=1 and btn_level[i]=1:
  - The repeat counter starts at press.
  - The first repeat_pulse occurs REPEAT_DELAY cycles after press_pulse.
  - Subsequent pulses occur every REPEAT_RATE cycles.
  - The counter clears on release or when repeat_en[i] drops; no repeat is generated in the release cycle.
  - repeat_en rising while the button is held restarts the delay from that cycle.
- Pending slots:
  - Each channel has a 1-entry pending slot {valid, type}; every pulse loads that channel's slot.
  - If the slot is already valid when a new pulse arrives, the new event is dropped and overflow is set.
- Arbiter:
  - Each cycle, the lowest-index channel with a valid slot is pushed into the FIFO if the FIFO is not full, or is full but popping that same cycle.
  - The pushed slot is cleared; at most 1 push per cycle.
  - A slot being pushed may be reloaded in the same cycle without overflow.
- FIFO:
  - First-word-fall-through: evt_ch/evt_type are valid whenever evt_valid=1 and stay stable until popped.
  - Pop occurs when evt_valid && evt_ready.
  - evt_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
  - A push into an empty FIFO raises evt_valid on the next cycle (1-cycle latency from slot to evt_valid).
- overflow:
  - Set beats clear when both happen in the same cycle.
  - overflow_clr with no new loss clears it on the next edge.
- Reset mid-operation:
  - Events in flight are discarded.
  - A button held through reset is re-accepted as a press 2+DEB_CYCLES cycles after reset releases.

Test Plan:
Use N_CH=3, DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5, FIFO_DEPTH=4.
- Hold btn_in[0]=1 from cycle 0 with evt_ready=1 -> btn_level[0] and press_pulse[0] at cycle 6; evt_valid=1 at cycle 7 with evt_ch=0, evt_type=01, then evt_valid=0.
- Pulse btn_in[1] high for 3 cycles -> no btn_level change, no events.
- Glitch btn_in[1] high 3 cycles, low 1, high 10 -> btn_level[1] rises exactly 6 cycles after the final rising edge.
- repeat_en[2]=1, hold btn_in[2] for 40 cycles -> press, then repeat_pulse at +10, +15, +20, ...; release queued as type 10; no repeat in the release cycle.
- All three buttons pressed in the same cycle, evt_ready=1 -> FIFO delivers ch0, ch1, ch2 press events on consecutive cycles.
- Second burst: evt_ready=0, keep generating events until 4 are queued plus one more per slot -> evt_valid stays high; overflow=1 once a second event hits a full slot; overflow_clr then clears it.
- Assert reset=0 for 1 cycle mid-repeat with the button held -> all outputs 0, FIFO empty; a new press event is queued 6 cycles after reset returns to 1.
